alu_op_decoder: RTL
===================

# alu_op_decoder

Registered decode stage that turns a fetched RV32I instruction into the ALU command (`alu_op`, operand A, operand B) plus writeback control for the execute stage. It is the initiator side of the ALU operand/op interface and sits between fetch and execute in the 3-stage pipeline. It holds one instruction in a valid/ready pipeline register, with stall backpressure and flush.

## Interface
- `Data_Width`, 32, width of instruction, PC, register data and operands
- `Op_Width`, 4, width of `alu_op_o`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `instr_i`  in  Data_Width  instruction word from fetch
- `pc_i`  in  Data_Width  PC of `instr_i`
- `rs1_data_i`, `rs2_data_i`  in  Data_Width  register-file read data for `instr_i`
- `valid_i`  in  1  `instr_i` is valid
- `ready_o`  out  1  stage can accept `instr_i` this cycle
- `flush_i`  in  1  discard the held entry and any incoming entry
- `alu_op_o`  out  Op_Width  ALU opcode
- `operand_a_o`, `operand_b_o`  out  Data_Width  ALU operands
- `rs2_data_o`  out  Data_Width  store data
- `rd_o`  out  5  destination register
- `wr_en_o`  out  1  writeback enable; forced 0 when `rd` = 0
- `mem_rd_o`, `mem_wr_o`  out  1  load/store
- `illegal_o`  out  1  undecodable instruction
- `valid_o`  out  1  outputs hold a valid command
- `ready_i`  in  1  execute accepts the command

## Operation
- ALU codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- OP (0110011) decode:
  - funct3 maps 000→ADD/SUB (SUB when funct7 = 0100000), 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101→SRL/SRA (SRA when funct7 = 0100000), 110→OR, 111→AND.
  - A = rs1, B = rs2.
- OP-IMM (0010011) decode:
  - Same funct3 map, but funct7 selects only for 101.
  - B = sign-extended imm[11:0]. For shifts, B = zero-extended shamt[4:0].
- LUI: A = 0, B = {imm[31:12], 12'b0}, ADD.
- AUIPC: A = pc, B = U-imm, ADD.
- LOAD/STORE:
  - A = rs1, B = I-imm or S-imm, ADD.
  - `mem_rd_o`/`mem_wr_o` set. STORE has `wr_en_o` = 0.
- JAL/JALR: A = pc, B = 4, ADD, `wr_en_o` = 1 (link value).
- BRANCH: A = rs1, B = rs2, SUB, `wr_en_o` = 0.
- All immediates are sign-extended to Data_Width from bit 31 of `instr_i`.

## Timing
- Latency is 1 cycle: an accepted instruction appears on the outputs on the next rising edge.
- `ready_o` = `!valid_o || ready_i` (combinational). Accept occurs when `valid_i && ready_o`.
- State is a single bit, EMPTY/FULL (= `valid_o`):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `ready_i && !valid_i`.
  - FULL→FULL on `ready_i && valid_i` (back-to-back, no bubble).
  - FULL with `!ready_i`: all outputs hold stable.
- Flush:
  - `flush_i` wins over everything: next state is EMPTY and the incoming instruction is dropped.
  - Data registers may update, but `valid_o` = 0.
- Reset, including mid-operation: all outputs 0 (`alu_op_o` = ADD, `valid_o` = 0). `ready_o` = 1 while EMPTY.
- Control outputs are qualified by `valid_o`. `wr_en_o`, `mem_rd_o`, `mem_wr_o` and `illegal_o` are 0 whenever `valid_o` = 0.

## Configuration
- `ALU_DEC_ILLEGAL_EN`, when defined:
  - Unknown opcode, or bad funct7 on OP/shift-imm, sets `illegal_o` = 1.
  - The instruction still occupies a slot with `alu_op_o` = ADD and `wr_en_o`/`mem_*` = 0.
- Undefined:
  - `illegal_o` is tied 0.
  - Unknown instructions decode as a bubble-like ADD with all enables 0; funct7 is ignored except bit 30.

## Structure
- Shared package `alu_pkg`: ALU opcode localparams/enum (shared with the ALU), RV32I opcode constants, immediate-type enum.
- One sub-module, `imm_gen`: combinational immediate extraction (I/S/B/U/J) from `instr_i`.

## Test plan
- ADD: `0x002081B3`, rs1 = 5, rs2 = 7 → next cycle `alu_op_o` = 0000, A = 5, B = 7, `rd_o` = 3, `wr_en_o` = 1, `valid_o` = 1.
- SUB and SRAI:
  - `0x402081B3` → `alu_op_o` = 0001.
  - `0x4030D293` → `alu_op_o` = 0111, B = 3, `rd_o` = 5.
- Immediates:
  - ADDI `0xFFF00093` → B = `0xFFFFFFFF`, `rd_o` = 1.
  - LUI `0x123450B7` → A = 0, B = `0x12345000`.
- Backpressure: FULL, `ready_i` = 0 for 3 cycles with new `valid_i` → outputs unchanged, `ready_o` = 0. When `ready_i` rises, the new instruction appears the next cycle with no bubble.
- Flush: `flush_i` = 1 with `valid_i` = 1 while FULL → next cycle `valid_o` = 0 and `wr_en_o` = 0.
- Reset mid-operation: assert `rst` asynchronously while FULL → `valid_o` = 0 and all outputs 0 immediately, without waiting for a clock edge.
- With `ALU_DEC_ILLEGAL_EN` defined: `0x0000007F` → `illegal_o` = 1, `wr_en_o` = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the decode stage and the ALU:
//   - alu_op_e     : 4-bit ALU opcode encoding
//   - OPC_*        : RV32I major opcode constants (instr[6:0])
//   - FUNCT7_*     : funct7 values that are meaningful for OP / shift-imm
//   - imm_type_e   : immediate format selector for imm_gen
//   - funct3_to_op : funct3 (+ alternate bit) to ALU opcode mapping
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   // alt selects SUB over ADD and SRA over SRL; it is ignored for other funct3.
   function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      unique case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational immediate extraction for the RV32I I/S/B/U/J formats. Every
// immediate is sign-extended from instruction bit 31 to Data_Width.
// Ports:
//   instr_i    in  [31:7]         instruction bits above the opcode field
//   imm_type_i in  imm_type_e     format to extract
//   imm_o      out [Data_Width]   sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
   import alu_pkg::*;
#(
   parameter int Data_Width = 32
) (
   input  logic [31:7]           instr_i,
   input  imm_type_e             imm_type_i,
   output logic [Data_Width-1:0] imm_o
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      unique case (imm_type_i)
         IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   imm32 = {instr_i[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      // Signed size cast keeps the sign extension for Data_Width > 32.
      imm_o = Data_Width'(imm32);
   end

endmodule

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Registered decode stage between fetch and execute. Turns one RV32I
// instruction into an ALU command (opcode, operand A, operand B) plus
// writeback / memory control, held in a single valid/ready pipeline slot.
// Optional feature macro: ALU_DEC_ILLEGAL_EN (flag undecodable instructions
// on illegal_o; otherwise illegal_o is tied 0 and unknown instructions become
// an ADD with all enables cleared).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   instr_i, pc_i             instruction word and its PC from fetch
//   rs1_data_i, rs2_data_i    register-file read data for instr_i
//   valid_i / ready_o         upstream handshake (ready_o = !valid_o || ready_i)
//   flush_i                   drop held and incoming entry
//   alu_op_o                  ALU opcode
//   operand_a_o, operand_b_o  ALU operands
//   rs2_data_o                store data
//   rd_o, wr_en_o             destination register and writeback enable
//   mem_rd_o, mem_wr_o        load / store
//   illegal_o                 undecodable instruction
//   valid_o / ready_i         downstream handshake
// -----------------------------------------------------------------------------
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int Data_Width = 32,
   parameter int Op_Width   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [Data_Width-1:0] instr_i,
   input  logic [Data_Width-1:0] pc_i,
   input  logic [Data_Width-1:0] rs1_data_i,
   input  logic [Data_Width-1:0] rs2_data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  flush_i,
   output logic [Op_Width-1:0]   alu_op_o,
   output logic [Data_Width-1:0] operand_a_o,
   output logic [Data_Width-1:0] operand_b_o,
   output logic [Data_Width-1:0] rs2_data_o,
   output logic [4:0]            rd_o,
   output logic                  wr_en_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic                  illegal_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic                  is_shift_imm;
   imm_type_e             imm_type;
   logic [Data_Width-1:0] imm;

   alu_op_e               alu_op_d;
   logic [Op_Width-1:0]   alu_op_q;
   logic [Data_Width-1:0] operand_a_d, operand_a_q;
   logic [Data_Width-1:0] operand_b_d, operand_b_q;
   logic [Data_Width-1:0] rs2_data_q;
   logic [4:0]            rd_d, rd_q;
   logic                  wr_en_d, wr_en_q;
   logic                  mem_rd_d, mem_rd_q;
   logic                  mem_wr_d, mem_wr_q;
   logic                  illegal_d, illegal_q;
   logic                  valid_d, valid_q;
   logic                  accept;

   assign opcode       = instr_i[6:0];
   assign funct3       = instr_i[14:12];
   assign funct7       = instr_i[31:25];
   assign rd_d         = instr_i[11:7];
   assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

   imm_gen #(
      .Data_Width (Data_Width)
   ) u_imm_gen (
      .instr_i    (instr_i[31:7]),
      .imm_type_i (imm_type),
      .imm_o      (imm)
   );

   // ---- decode (combinational, feeds the pipeline register) ----
   always_comb begin
      alu_op_d    = ALU_ADD;
      operand_a_d = '0;
      operand_b_d = '0;
      wr_en_d     = 1'b0;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      illegal_d   = 1'b0;
      imm_type    = IMM_I;

      unique case (opcode)
         OPC_OP: begin
            operand_a_d = rs1_data_i;
            operand_b_d = rs2_data_i;
            wr_en_d     = 1'b1;
            alu_op_d    = funct3_to_op(funct3, instr_i[30]);
`ifdef ALU_DEC_ILLEGAL_EN
            if (!((funct7 == FUNCT7_BASE) ||
                  ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))))) begin
               illegal_d = 1'b1;
               alu_op_d  = ALU_ADD;
               wr_en_d   = 1'b0;
            end
`endif
         end
         OPC_OP_IMM: begin
            operand_a_d = rs1_data_i;
            wr_en_d     = 1'b1;
            if (is_shift_imm) begin
               // Shift amount is unsigned; only funct3=101 uses bit 30 (SRAI).
               operand_b_d = Data_Width'(instr_i[24:20]);
               alu_op_d    = funct3_to_op(funct3, funct3[2] & instr_i[30]);
`ifdef ALU_DEC_ILLEGAL_EN
               if (!((funct7 == FUNCT7_BASE) ||
                     ((funct7 == FUNCT7_ALT) && funct3[2]))) begin
                  illegal_d = 1'b1;
                  alu_op_d  = ALU_ADD;
                  wr_en_d   = 1'b0;
               end
`endif
            end else begin
               operand_b_d = imm;
               alu_op_d    = funct3_to_op(funct3, 1'b0);
            end
         end
         OPC_LUI: begin
            imm_type    = IMM_U;
            operand_b_d = imm;
            wr_en_d     = 1'b1;
         end
         OPC_AUIPC: begin
            imm_type    = IMM_U;
            operand_a_d = pc_i;
            operand_b_d = imm;
            wr_en_d     = 1'b1;
         end
         OPC_LOAD: begin
            operand_a_d = rs1_data_i;
            operand_b_d = imm;
            mem_rd_d    = 1'b1;
            wr_en_d     = 1'b1;
         end
         OPC_STORE: begin
            imm_type    = IMM_S;
            operand_a_d = rs1_data_i;
            operand_b_d = imm;
            mem_wr_d    = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            // ALU computes the link value pc+4.
            operand_a_d = pc_i;
            operand_b_d = Data_Width'(32'd4);
            wr_en_d     = 1'b1;
         end
         OPC_BRANCH: begin
            operand_a_d = rs1_data_i;
            operand_b_d = rs2_data_i;
            alu_op_d    = ALU_SUB;
         end
         default: begin
`ifdef ALU_DEC_ILLEGAL_EN
            illegal_d = 1'b1;
`endif
         end
      endcase

      if (rd_d == 5'd0) begin
         wr_en_d = 1'b0;
      end
   end

   // ---- handshake / slot state (EMPTY = !valid_q, FULL = valid_q) ----
   assign ready_o = !valid_q || ready_i;
   assign accept  = valid_i && ready_o;

   always_comb begin
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (ready_o) begin
         valid_d = valid_i;
      end
   end

   // ---- pipeline register: decode -> execute ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         alu_op_q    <= Op_Width'(ALU_ADD);
         operand_a_q <= '0;
         operand_b_q <= '0;
         rs2_data_q  <= '0;
         rd_q        <= '0;
         wr_en_q     <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         // Data may load during a flush; valid_q masks it below.
         if (accept) begin
            alu_op_q    <= Op_Width'(alu_op_d);
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            rs2_data_q  <= rs2_data_i;
            rd_q        <= rd_d;
            wr_en_q     <= wr_en_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            illegal_q   <= illegal_d;
         end
      end
   end

   assign valid_o     = valid_q;
   assign alu_op_o    = alu_op_q;
   assign operand_a_o = operand_a_q;
   assign operand_b_o = operand_b_q;
   assign rs2_data_o  = rs2_data_q;
   assign rd_o        = rd_q;
   assign wr_en_o     = valid_q & wr_en_q;
   assign mem_rd_o    = valid_q & mem_rd_q;
   assign mem_wr_o    = valid_q & mem_wr_q;
   assign illegal_o   = valid_q & illegal_q;

endmodule
